// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one valid/ready slot that holds a decoded bundle,
// decodes the ALU operation at capture and forwards operands from EX/MEM and MEM/WB.
module id_ex_stage #(
    parameter int DATA_WIDTH    = 64,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [4:0]               rd,
    input  logic                     alu_src,
    input  logic [1:0]               alu_op,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic                     reg_write,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic                     mem_to_reg,
    input  logic                     flush,
    input  logic                     exmem_reg_write,
    input  logic [4:0]               exmem_rd,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic                     memwb_reg_write,
    input  logic [4:0]               memwb_rd,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] ALUCC,
    output logic [DATA_WIDTH-1:0]    store_data,
    output logic [4:0]               rd_out,
    output logic                     reg_write_out,
    output logic                     mem_read_out,
    output logic                     mem_write_out,
    output logic                     mem_to_reg_out
);

    localparam logic [OPCODE_LENGTH-1:0] ALU_MUL = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] ALU_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = OPCODE_LENGTH'(4'b0110);

    // Unrecognised R-type encodings and the reserved alu_op fall back to ADD.
    function automatic logic [OPCODE_LENGTH-1:0] decode_alucc(
        input logic [1:0] op,
        input logic [2:0] f3,
        input logic [6:0] f7
    );
        logic [OPCODE_LENGTH-1:0] code;
        code = ALU_ADD;
        case (op)
            2'b00: code = ALU_ADD;
            2'b01: code = ALU_SUB;
            2'b10: begin
                if (f3 == 3'b000) begin
                    case (f7)
                        7'b0000001: code = ALU_MUL;
                        7'b0000000: code = ALU_ADD;
                        7'b0100000: code = ALU_SUB;
                        default:    code = ALU_ADD;
                    endcase
                end else if (f3 == 3'b110) begin
                    code = ALU_OR;
                end else begin
                    code = ALU_ADD;
                end
            end
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    // EX/MEM wins over MEM/WB; x0 is hardwired and never forwarded.
    function automatic logic [DATA_WIDTH-1:0] forward_operand(
        input logic [4:0]            src,
        input logic [DATA_WIDTH-1:0] reg_value,
        input logic                  ex_we,
        input logic [4:0]            ex_rd,
        input logic [DATA_WIDTH-1:0] ex_value,
        input logic                  wb_we,
        input logic [4:0]            wb_rd,
        input logic [DATA_WIDTH-1:0] wb_value
    );
        logic [DATA_WIDTH-1:0] result;
        result = reg_value;
        if (src == 5'd0) begin
            result = reg_value;
        end else if (ex_we && (ex_rd == src)) begin
            result = ex_value;
        end else if (wb_we && (wb_rd == src)) begin
            result = wb_value;
        end else begin
            result = reg_value;
        end
        return result;
    endfunction

    logic                     valid_r;
    logic [DATA_WIDTH-1:0]    rs1_data_r;
    logic [DATA_WIDTH-1:0]    rs2_data_r;
    logic [DATA_WIDTH-1:0]    imm_r;
    logic [4:0]               rs1_r;
    logic [4:0]               rs2_r;
    logic [4:0]               rd_r;
    logic                     alu_src_r;
    logic [OPCODE_LENGTH-1:0] alucc_r;
    logic                     reg_write_r;
    logic                     mem_read_r;
    logic                     mem_write_r;
    logic                     mem_to_reg_r;

    logic                     in_ready_s;
    logic                     take_in_s;
    logic                     take_out_s;
    logic [DATA_WIDTH-1:0]    fwd_a_s;
    logic [DATA_WIDTH-1:0]    fwd_b_s;
    logic [DATA_WIDTH-1:0]    src_b_s;

    assign in_ready_s = (!valid_r || out_ready) && !flush;
    assign take_in_s  = in_valid && in_ready_s;
    assign take_out_s = valid_r && out_ready;

    // Slot register: reset beats flush, flush beats capture, capture beats drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r      <= 1'b0;
            rs1_data_r   <= {DATA_WIDTH{1'b0}};
            rs2_data_r   <= {DATA_WIDTH{1'b0}};
            imm_r        <= {DATA_WIDTH{1'b0}};
            rs1_r        <= 5'd0;
            rs2_r        <= 5'd0;
            rd_r         <= 5'd0;
            alu_src_r    <= 1'b0;
            alucc_r      <= {OPCODE_LENGTH{1'b0}};
            reg_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (take_in_s) begin
            valid_r      <= 1'b1;
            rs1_data_r   <= rs1_data;
            rs2_data_r   <= rs2_data;
            imm_r        <= imm;
            rs1_r        <= rs1;
            rs2_r        <= rs2;
            rd_r         <= rd;
            alu_src_r    <= alu_src;
            alucc_r      <= decode_alucc(alu_op, funct3, funct7);
            reg_write_r  <= reg_write;
            mem_read_r   <= mem_read;
            mem_write_r  <= mem_write;
            mem_to_reg_r <= mem_to_reg;
        end else if (take_out_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Operands are re-forwarded every cycle so a stalled bundle sees newly retired results.
    always_comb begin
        fwd_a_s = forward_operand(rs1_r, rs1_data_r, exmem_reg_write, exmem_rd, exmem_result,
                                  memwb_reg_write, memwb_rd, memwb_result);
        fwd_b_s = forward_operand(rs2_r, rs2_data_r, exmem_reg_write, exmem_rd, exmem_result,
                                  memwb_reg_write, memwb_rd, memwb_result);
        if (alu_src_r) begin
            src_b_s = imm_r;
        end else begin
            src_b_s = fwd_b_s;
        end
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = valid_r;
    assign SrcA           = fwd_a_s;
    assign SrcB           = src_b_s;
    assign store_data     = fwd_b_s;
    assign ALUCC          = alucc_r;
    assign rd_out         = rd_r;
    assign reg_write_out  = reg_write_r;
    assign mem_read_out   = mem_read_r;
    assign mem_write_out  = mem_write_r;
    assign mem_to_reg_out = mem_to_reg_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: decode table, hand-written stall/forward/flush/reset
// sequences, then randomized traffic against a cycle-level reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, alu_src, flush, out_valid, out_ready;
    logic [63:0] rs1_data, rs2_data, imm, exmem_result, memwb_result;
    logic [63:0] SrcA, SrcB, store_data;
    logic [4:0]  rs1, rs2, rd, exmem_rd, memwb_rd, rd_out;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [3:0]  ALUCC;
    logic        reg_write, mem_read, mem_write, mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out;

    int nvec = 0;
    int nerr = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd), .alu_src(alu_src), .alu_op(alu_op),
        .funct3(funct3), .funct7(funct7), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready), .SrcA(SrcA), .SrcB(SrcB),
        .ALUCC(ALUCC), .store_data(store_data), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] a, b, im;
        logic        src;
        logic [3:0]  aluc;
        logic [63:0] srca, srcb, st;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [63:0] a, b, im;
        logic [4:0]  rs1, rs2, rd;
        logic        src;
        logic [3:0]  aluc;
        logic [3:0]  ctl;
    } model_t;

    vec_t   tbl[9];
    model_t m;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        rs1_data = 64'd0; rs2_data = 64'd0; imm = 64'd0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; alu_src = 1'b0;
        alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'b0000000;
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 64'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 64'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_bundle(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                              input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] im,
                              input logic src, input logic [1:0] op);
        rs1 = r1; rs2 = r2; rd = rdd; rs1_data = d1; rs2_data = d2; imm = im;
        alu_src = src; alu_op = op; funct3 = 3'b000; funct7 = 7'b0000000;
        reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_to_reg = 1'b1;
    endtask

    // Decode table written straight from the operation list.
    function automatic logic [3:0] ref_alucc(input logic [1:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7);
        if (op == 2'b01) return 4'b0110;
        if (op != 2'b10) return 4'b0010;
        if (f3 == 3'b110) return 4'b0001;
        if (f3 == 3'b000 && f7 == 7'b0000001) return 4'b0000;
        if (f3 == 3'b000 && f7 == 7'b0100000) return 4'b0110;
        return 4'b0010;
    endfunction

    function automatic logic [63:0] ref_fwd(input logic [4:0] r, input logic [63:0] v);
        if (r != 5'd0 && exmem_reg_write && exmem_rd == r) return exmem_result;
        if (r != 5'd0 && memwb_reg_write && memwb_rd == r) return memwb_result;
        return v;
    endfunction

    task automatic check_model(input string tag);
        logic [63:0] fb;
        fb = ref_fwd(m.rs2, m.b);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'((!m.valid || out_ready) && !flush));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m.valid));
        chk({tag, ".SrcA"}, SrcA, ref_fwd(m.rs1, m.a));
        chk({tag, ".SrcB"}, SrcB, m.src ? m.im : fb);
        chk({tag, ".store_data"}, store_data, fb);
        chk({tag, ".ALUCC"}, 64'(ALUCC), 64'(m.aluc));
        chk({tag, ".rd_out"}, 64'(rd_out), 64'(m.rd));
        chk({tag, ".ctl"}, 64'({reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out}),
            64'(m.ctl));
    endtask

    task automatic model_edge();
        if (reset) begin
            m = '{valid: 1'b0, a: 64'd0, b: 64'd0, im: 64'd0, rs1: 5'd0, rs2: 5'd0,
                  rd: 5'd0, src: 1'b0, aluc: 4'd0, ctl: 4'd0};
        end else if (flush) begin
            m.valid = 1'b0;
        end else if (in_valid && (!m.valid || out_ready)) begin
            m = '{valid: 1'b1, a: rs1_data, b: rs2_data, im: imm, rs1: rs1, rs2: rs2, rd: rd,
                  src: alu_src, aluc: ref_alucc(alu_op, funct3, funct7),
                  ctl: {reg_write, mem_read, mem_write, mem_to_reg}};
        end else if (out_ready) begin
            m.valid = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tbl[0] = '{2'b10, 3'b000, 7'b0000001, 64'd6, 64'd7, 64'd0, 1'b0, 4'b0000, 64'd6, 64'd7, 64'd7};
        tbl[1] = '{2'b00, 3'b010, 7'b0000000, 64'd3, 64'd4, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 4'b0010,
                   64'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'd4};
        tbl[2] = '{2'b01, 3'b000, 7'b0000000, 64'd9, 64'd5, 64'd1, 1'b0, 4'b0110, 64'd9, 64'd5, 64'd5};
        tbl[3] = '{2'b10, 3'b000, 7'b0000000, 64'd1, 64'd2, 64'd0, 1'b0, 4'b0010, 64'd1, 64'd2, 64'd2};
        tbl[4] = '{2'b10, 3'b000, 7'b0100000, 64'd8, 64'd3, 64'd0, 1'b0, 4'b0110, 64'd8, 64'd3, 64'd3};
        tbl[5] = '{2'b10, 3'b110, 7'b0100000, 64'hA, 64'h5, 64'd0, 1'b0, 4'b0001, 64'hA, 64'h5, 64'h5};
        tbl[6] = '{2'b10, 3'b111, 7'b0000000, 64'd4, 64'd4, 64'd0, 1'b0, 4'b0010, 64'd4, 64'd4, 64'd4};
        tbl[7] = '{2'b11, 3'b000, 7'b0000001, 64'd2, 64'd3, 64'd0, 1'b0, 4'b0010, 64'd2, 64'd3, 64'd3};
        tbl[8] = '{2'b10, 3'b000, 7'b0000011, 64'd5, 64'd6, 64'd0, 1'b0, 4'b0010, 64'd5, 64'd6, 64'd6};

        tick();
        tick();
        reset = 1'b0;
        settle();
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.ALUCC", 64'(ALUCC), 64'd0);
        chk("rst.SrcA", SrcA, 64'd0);

        // Decode/operand table, one bundle per cycle with out_ready high.
        for (int i = 0; i < 9; i++) begin
            set_bundle(5'd1, 5'd2, 5'(i + 3), tbl[i].a, tbl[i].b, tbl[i].im, tbl[i].src, tbl[i].op);
            funct3 = tbl[i].f3; funct7 = tbl[i].f7; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            settle();
            chk($sformatf("tbl%0d.out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("tbl%0d.ALUCC", i), 64'(ALUCC), 64'(tbl[i].aluc));
            chk($sformatf("tbl%0d.SrcA", i), SrcA, tbl[i].srca);
            chk($sformatf("tbl%0d.SrcB", i), SrcB, tbl[i].srcb);
            chk($sformatf("tbl%0d.store", i), store_data, tbl[i].st);
            chk($sformatf("tbl%0d.rd_out", i), 64'(rd_out), 64'(i + 3));
        end

        // Three-cycle stall with a waiting bundle, then release.
        do_reset();
        idle_inputs();
        set_bundle(5'd1, 5'd2, 5'd1, 64'd11, 64'd0, 64'd0, 1'b0, 2'b00);
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        set_bundle(5'd1, 5'd2, 5'd2, 64'd22, 64'd0, 64'd0, 1'b0, 2'b01);
        settle();
        for (int k = 0; k < 3; k++) begin
            chk("stall.in_ready", 64'(in_ready), 64'd0);
            chk("stall.out_valid", 64'(out_valid), 64'd1);
            chk("stall.rd_out", 64'(rd_out), 64'd1);
            chk("stall.SrcA", SrcA, 64'd11);
            chk("stall.ALUCC", 64'(ALUCC), 64'd2);
            tick();
        end
        out_ready = 1'b1;
        settle();
        chk("release.in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        settle();
        chk("release.rd_out", 64'(rd_out), 64'd2);
        chk("release.SrcA", SrcA, 64'd22);
        chk("release.ALUCC", 64'(ALUCC), 64'd6);
        tick();
        chk("drain.out_valid", 64'(out_valid), 64'd0);

        // Forwarding priority on a held bundle.
        set_bundle(5'd5, 5'd7, 5'd9, 64'd1, 64'd3, 64'd0, 1'b0, 2'b00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 64'd100;
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 64'd200;
        settle();
        chk("fwd.exmem", SrcA, 64'd100);
        exmem_reg_write = 1'b0;
        settle();
        chk("fwd.memwb", SrcA, 64'd200);
        memwb_reg_write = 1'b0;
        settle();
        chk("fwd.none", SrcA, 64'd1);

        // Immediate operand with a forwarded store value.
        out_ready = 1'b1;
        set_bundle(5'd4, 5'd7, 5'd9, 64'd1, 64'd3, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 2'b00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd = 5'd7; exmem_result = 64'd9;
        settle();
        chk("imm.SrcB", SrcB, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("imm.store", store_data, 64'd9);
        chk("imm.ALUCC", 64'(ALUCC), 64'd2);

        // x0 is never forwarded.
        set_bundle(5'd0, 5'd0, 5'd9, 64'd0, 64'd0, 64'd0, 1'b0, 2'b00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 64'd55;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 64'd77;
        settle();
        chk("x0.SrcA", SrcA, 64'd0);
        chk("x0.store", store_data, 64'd0);

        // Flush with a waiting bundle, then reset overriding flush and capture.
        idle_inputs();
        set_bundle(5'd3, 5'd4, 5'd12, 64'd31, 64'd41, 64'd0, 1'b0, 2'b01);
        in_valid = 1'b1;
        tick();
        flush = 1'b1;
        settle();
        chk("flush.in_ready", 64'(in_ready), 64'd0);
        chk("flush.pre_valid", 64'(out_valid), 64'd1);
        tick();
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        tick();
        chk("recap.out_valid", 64'(out_valid), 64'd1);
        reset = 1'b1; flush = 1'b1;
        tick();
        chk("rst2.out_valid", 64'(out_valid), 64'd0);
        chk("rst2.rd_out", 64'(rd_out), 64'd0);
        chk("rst2.ALUCC", 64'(ALUCC), 64'd0);
        chk("rst2.SrcA", SrcA, 64'd0);
        chk("rst2.SrcB", SrcB, 64'd0);
        chk("rst2.store", store_data, 64'd0);
        chk("rst2.ctl", 64'({reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out}), 64'd0);
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        settle();
        chk("rst2.in_ready", 64'(in_ready), 64'd1);

        // Randomized traffic against the reference model.
        do_reset();
        m = '{valid: 1'b0, a: 64'd0, b: 64'd0, im: 64'd0, rs1: 5'd0, rs2: 5'd0,
              rd: 5'd0, src: 1'b0, aluc: 4'd0, ctl: 4'd0};
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 39) == 0);
            flush     = ($urandom_range(0, 11) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
            imm = {$urandom, $urandom};
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            rd = 5'($urandom); alu_src = 1'($urandom);
            alu_op = 2'($urandom); funct3 = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
            case ($urandom_range(0, 3))
                0:       funct7 = 7'b0000001;
                1:       funct7 = 7'b0100000;
                2:       funct7 = 7'b0000000;
                default: funct7 = 7'($urandom);
            endcase
            {reg_write, mem_read, mem_write, mem_to_reg} = 4'($urandom);
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
            exmem_result = {$urandom, $urandom};
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
            memwb_result = {$urandom, $urandom};
            settle();
            check_model("rnd");
            @(posedge clk);
            model_edge();
            #1;
        end
        reset = 1'b0; flush = 1'b0;
        settle();
        check_model("rnd_end");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the width of all operand, immediate and result buses.
REQ-002 Parameter OPCODE_LENGTH, default 4, SHALL set the width of ALUCC.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  decode bundle valid
- in_ready  out  1  stage can accept bundle
- rs1_data, rs2_data  in  DATA_WIDTH  register-file read data
- imm  in  DATA_WIDTH  sign-extended immediate
- rs1, rs2, rd  in  5  register addresses
- alu_src  in  1  1: SrcB=imm, 0: SrcB=rs2 operand
- alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 reserved
- funct3  in  3; funct7  in  7  instruction fields
- reg_write, mem_read, mem_write, mem_to_reg  in  1  control bits
- flush  in  1  discard held bundle
- exmem_reg_write  in  1; exmem_rd  in  5; exmem_result  in  DATA_WIDTH  EX/MEM forward source
- memwb_reg_write  in  1; memwb_rd  in  5; memwb_result  in  DATA_WIDTH  MEM/WB forward source
- out_valid  out  1  bundle valid toward ALU
- out_ready  in  1  downstream accepts bundle
- SrcA, SrcB  out  DATA_WIDTH  ALU operands
- ALUCC  out  OPCODE_LENGTH  ALU operation code
- store_data  out  DATA_WIDTH  forwarded rs2 operand
- rd_out  out  5; reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out  out  1  registered control

Function
REQ-004 Stage SHALL be a single register slot; accepted bundle appears at outputs the cycle after the accepting edge (latency 1).
REQ-005 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-006 Transfer in SHALL occur on an edge where in_valid && in_ready; transfer out on an edge where out_valid && out_ready.
REQ-007 Simultaneous transfer out and in SHALL replace the slot contents with no bubble; out_valid stays 1.
REQ-008 Transfer out without transfer in SHALL clear out_valid.
REQ-009 While out_valid && !out_ready, all registered outputs SHALL hold stable.
REQ-010 flush SHALL clear out_valid at the next edge and override any capture or hold; data registers may retain stale values.
REQ-011 ALUCC SHALL be registered at capture from alu_op/funct fields: alu_op 00 -> 0010 (ADD); 01 -> 0110 (SUB); 10 with funct7=0000001,funct3=000 -> 0000 (MUL); 10 with funct7=0000000,funct3=000 -> 0010; 10 with funct7=0100000,funct3=000 -> 0110; 10 with funct3=110 -> 0001 (OR); all other combinations, including alu_op 11 -> 0010.
REQ-012 Forwarded operand A SHALL be computed combinationally each cycle from registered rs1: exmem_result if exmem_reg_write && exmem_rd==rs1 && rs1!=0; else memwb_result if memwb_reg_write && memwb_rd==rs1 && rs1!=0; else registered rs1_data.
REQ-013 Forwarded operand B SHALL follow the same rule using registered rs2 and rs2_data; EX/MEM SHALL have priority over MEM/WB.
REQ-014 SrcA SHALL equal forwarded operand A; SrcB SHALL equal registered imm when registered alu_src=1, else forwarded operand B.
REQ-015 store_data SHALL always equal forwarded operand B regardless of alu_src.
REQ-016 Register x0 SHALL never be forwarded; a bundle with rs1=0 SHALL present registered rs1_data unchanged.
REQ-017 Control outputs SHALL reflect the captured bundle only; consumers SHALL qualify them with out_valid.

Reset
REQ-018 When reset is high at an edge, out_valid SHALL become 0 and all registered data, address, ALUCC and control outputs SHALL become 0; reset SHALL override flush and capture.
REQ-019 Reset asserted mid-stall SHALL discard the held bundle; in_ready SHALL be 1 in the first cycle after reset deasserts (flush low).

Verification
REQ-020 Reset, then in_valid with alu_op=10,funct7=0000001,funct3=000,rs1_data=6,rs2_data=7 -> next cycle out_valid=1, ALUCC=0000, SrcA=6, SrcB=7.
REQ-021 Hold out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs unchanged; raise out_ready -> new bundle appears next cycle, no loss, no duplicate.
REQ-022 Held bundle rs1=5; exmem_reg_write=1,exmem_rd=5,exmem_result=100 and memwb_rd=5,memwb_result=200 -> SrcA=100; drop exmem_reg_write -> SrcA=200.
REQ-023 alu_src=1,imm=-8,alu_op=00 with rs2 forwarded as 9 -> SrcB=-8 (all ones except low 3 bits zero), ALUCC=0010, store_data=9.
REQ-024 rs1=0 with exmem_reg_write=1,exmem_rd=0,exmem_result=55,rs1_data=0 -> SrcA=0.
REQ-025 flush asserted with out_valid=1 and in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle; same with reset -> all outputs 0.
